gumnut_data_mem: RTL and testbench

GUMNUT_DATA_MEM -- requirements
Module: gumnut_data_mem

---
 rtl/gumnut_data_mem.sv | 130 +++++++++++++
 tb/tb_gumnut_data_mem.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gumnut_data_mem.sv
// ============================================================================
// gumnut_data_mem : wait-state configurable 8-bit data memory, Wishbone-style.
// Optional GUMNUT_DMEM_BOUNDS_EN: out-of-range addresses complete with err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gumnut_data_mem #(
  parameter int WAIT_STATES = 0,
  parameter int DEPTH       = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_cyc_i,
  input  logic       data_stb_i,
  input  logic       data_we_i,
  input  logic [7:0] data_adr_i,
  input  logic [7:0] data_dat_i,
  output logic [7:0] data_dat_o,
  output logic       data_ack_o,
  output logic       data_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  adr_q;
  logic [7:0]  dat_q;
  logic        we_q;
  logic [7:0]  rdata_q;
  logic        ack_q;
  logic        err_q;
  logic [7:0]  mem_q [DEPTH];

  logic          w_req;
  logic          w_oob;
  logic          w_mem_we;
  logic [AW-1:0] w_idx;

  assign w_req = data_cyc_i & data_stb_i;
  assign w_idx = adr_q[AW-1:0];

`ifdef GUMNUT_DMEM_BOUNDS_EN
  assign w_oob = ({1'b0, adr_q} >= 9'(DEPTH));
`else
  // Upper address bits wrap; they only matter for the bounds check.
  logic w_adr_unused;
  assign w_oob        = 1'b0;
  assign w_adr_unused = |adr_q;
`endif

  // Reset on the ACK edge suppresses the write, not just the ack.
  assign w_mem_we = (state_q == S_ACK) && we_q && !w_oob && !rst_i;

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      mem_q[w_idx] <= dat_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            adr_q <= data_adr_i;
            dat_q <= data_dat_i;
            we_q  <= data_we_i;
            if (WAIT_STATES > 0) begin
              cnt_q   <= 4'(WAIT_STATES - 1);
              state_q <= S_WAIT;
            end else begin
              state_q <= S_ACK;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          if (w_oob) begin
            err_q <= 1'b1;
          end else begin
            ack_q <= 1'b1;
            if (!we_q) begin
              rdata_q <= mem_q[w_idx];
            end
          end
          // A strobe still held here must be released before the next transfer.
          state_q <= w_req ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (!w_req) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_dat_o = rdata_q;
  assign data_ack_o = ack_q;
  assign data_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_gumnut_data_mem.sv
// ============================================================================
// tb_gumnut_data_mem : two instances (0 and 3 wait states) checked against a
// transaction-level reference model, plus directed literal expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gumnut_data_mem;

  localparam int NDUT = 2;
  localparam int WS0  = 0;
  localparam int DP0  = 256;
  localparam int WS1  = 3;
  localparam int DP1  = 128;
`ifdef GUMNUT_DMEM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [NDUT];
  logic       cyc [NDUT];
  logic       stb [NDUT];
  logic       we  [NDUT];
  logic [7:0] adr [NDUT];
  logic [7:0] dat [NDUT];
  logic [7:0] dout[NDUT];
  logic       ack [NDUT];
  logic       err [NDUT];

  gumnut_data_mem #(.WAIT_STATES(WS0), .DEPTH(DP0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .data_cyc_i(cyc[0]), .data_stb_i(stb[0]),
    .data_we_i(we[0]), .data_adr_i(adr[0]), .data_dat_i(dat[0]),
    .data_dat_o(dout[0]), .data_ack_o(ack[0]), .data_err_o(err[0])
  );

  gumnut_data_mem #(.WAIT_STATES(WS1), .DEPTH(DP1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .data_cyc_i(cyc[1]), .data_stb_i(stb[1]),
    .data_we_i(we[1]), .data_adr_i(adr[1]), .data_dat_i(dat[1]),
    .data_dat_o(dout[1]), .data_ack_o(ack[1]), .data_err_o(err[1])
  );

  int checks   = 0;
  int failures = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic int dp_of(input int d);
    return (d == 0) ? DP0 : DP1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is accepted when idle, completes WS+1 edges
  // later unless the strobe drops before then, and a held strobe must be
  // released before anything new is accepted.
  bit         m_active [NDUT];
  bit         m_hold   [NDUT];
  int         m_age    [NDUT];
  logic [7:0] m_adr    [NDUT];
  logic [7:0] m_dat    [NDUT];
  bit         m_we     [NDUT];
  bit         m_ack    [NDUT];
  bit         m_err    [NDUT];
  logic [7:0] m_dout   [NDUT];
  bit         m_known  [NDUT];
  logic [7:0] m_mem    [NDUT][256];
  bit         m_valid  [NDUT][256];

  task automatic complete(input int d);
    int idx;
    bit oob;
    idx = int'(m_adr[d]) % dp_of(d);
    oob = BOUNDS && (int'(m_adr[d]) >= dp_of(d));
    if (oob) begin
      m_err[d] = 1'b1;
    end else begin
      m_ack[d] = 1'b1;
      if (m_we[d]) begin
        m_mem[d][idx]   = m_dat[d];
        m_valid[d][idx] = 1'b1;
      end else begin
        m_dout[d]  = m_mem[d][idx];
        m_known[d] = m_valid[d][idx];
      end
    end
  endtask

  task automatic model_step(input int d);
    bit r;
    r = (cyc[d] === 1'b1) && (stb[d] === 1'b1);
    m_ack[d] = 1'b0;
    m_err[d] = 1'b0;
    if (rst[d]) begin
      m_active[d] = 1'b0;
      m_hold[d]   = 1'b0;
      m_dout[d]   = 8'h00;
      m_known[d]  = 1'b1;
    end else if (m_hold[d]) begin
      if (!r) m_hold[d] = 1'b0;
    end else if (m_active[d]) begin
      m_age[d]++;
      if (m_age[d] <= ws_of(d)) begin
        if (!r) m_active[d] = 1'b0;
      end else begin
        complete(d);
        m_active[d] = 1'b0;
        m_hold[d]   = r;
      end
    end else if (r) begin
      m_active[d] = 1'b1;
      m_age[d]    = 0;
      m_adr[d]    = adr[d];
      m_dat[d]    = dat[d];
      m_we[d]     = we[d];
    end
  endtask

  // Inputs change at negedge+1, so at the negedge they still hold the values
  // the preceding rising edge sampled.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        model_step(d);
        chk("model_ack", d, 32'(ack[d]), 32'(m_ack[d]));
        chk("model_err", d, 32'(err[d]), 32'(m_err[d]));
        if (m_known[d]) chk("model_dout", d, 32'(dout[d]), 32'(m_dout[d]));
      end
    end
  end

  // Holds the request for 'hold' rising edges, scrambling the other inputs
  // after the first one, and counts completions over the following cycles.
  task automatic xfer(input int d, input bit w, input logic [7:0] a,
                      input logic [7:0] v, input int hold, output int n_ack,
                      output int n_err, output int first_ack);
    n_ack = 0;
    n_err = 0;
    first_ack = -1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = v;
    for (int k = 0; k < hold + 6; k++) begin
      @(negedge clk); #1;
      if (ack[d]) begin
        n_ack++;
        if (first_ack < 0) first_ack = k;
      end
      if (err[d]) n_err++;
      if (k == hold - 1) begin
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end else if (k < hold - 1) begin
        we[d] = ~w; adr[d] = ~a; dat[d] = ~v;
      end
    end
  endtask

  initial begin
    int na, ne, fa, cnt;
    int left[NDUT];
    bit on[NDUT];

    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = 8'h00; dat[d] = 8'h00;
      left[d] = 0; on[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_ack", d, 32'(ack[d]), 32'h0);
      chk("reset_err", d, 32'(err[d]), 32'h0);
      chk("reset_dout", d, 32'(dout[d]), 32'h00);
      rst[d] = 1'b0;
    end

    // Zero wait states: request on the first edge after reset release.
    xfer(0, 1'b1, 8'h10, 8'hA5, 1, na, ne, fa);
    chk("ws0_wr_acks", 0, 32'(na), 32'd1);
    chk("ws0_wr_latency", 0, 32'(fa), 32'd1);
    xfer(0, 1'b0, 8'h10, 8'h00, 2, na, ne, fa);
    chk("ws0_rd_acks", 0, 32'(na), 32'd1);
    chk("ws0_rd_latency", 0, 32'(fa), 32'd1);
    chk("ws0_rd_data", 0, 32'(dout[0]), 32'hA5);

    // Three wait states: held strobe gives one ack four cycles out.
    xfer(1, 1'b1, 8'h20, 8'h5A, 6, na, ne, fa);
    chk("ws3_wr_latency", 1, 32'(fa), 32'd4);
    xfer(1, 1'b0, 8'h20, 8'h00, 9, na, ne, fa);
    chk("ws3_held_acks", 1, 32'(na), 32'd1);
    chk("ws3_held_latency", 1, 32'(fa), 32'd4);
    chk("ws3_rd_data", 1, 32'(dout[1]), 32'h5A);

    // Strobe dropped after one wait cycle aborts the write.
    xfer(1, 1'b1, 8'h20, 8'h3C, 2, na, ne, fa);
    chk("abort_acks", 1, 32'(na), 32'd0);
    xfer(1, 1'b0, 8'h20, 8'h00, 5, na, ne, fa);
    chk("abort_rd_data", 1, 32'(dout[1]), 32'h5A);

    // Reset during WAIT kills a write of 0x77 over 0x44.
    xfer(1, 1'b1, 8'h30, 8'h44, 5, na, ne, fa);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h30; dat[1] = 8'h77;
    repeat (2) begin @(negedge clk); #1; end
    rst[1] = 1'b1;
    @(negedge clk); #1;
    chk("rst_wait_ack", 1, 32'(ack[1]), 32'h0);
    chk("rst_wait_dout", 1, 32'(dout[1]), 32'h00);
    rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (ack[1]) cnt++;
    end
    chk("rst_wait_no_ack", 1, 32'(cnt), 32'd0);
    xfer(1, 1'b0, 8'h30, 8'h00, 5, na, ne, fa);
    chk("rst_wait_mem", 1, 32'(dout[1]), 32'h44);

    // Address 0x85 against a 128-entry memory.
    xfer(1, 1'b1, 8'h05, 8'h22, 5, na, ne, fa);
    xfer(1, 1'b1, 8'h85, 8'h11, 5, na, ne, fa);
    chk("oob_acks", 1, 32'(na), BOUNDS ? 32'd0 : 32'd1);
    chk("oob_errs", 1, 32'(ne), BOUNDS ? 32'd1 : 32'd0);
    xfer(1, 1'b0, 8'h05, 8'h00, 5, na, ne, fa);
    chk("oob_rd_data", 1, 32'(dout[1]), BOUNDS ? 32'h22 : 32'h11);

    // Randomized traffic: held/short strobes, scrambled inputs, sparse resets.
    repeat (3000) begin
      @(negedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
        rst[d] = ($urandom_range(0, 79) == 0);
        if (left[d] == 0) begin
          on[d]   = !on[d];
          left[d] = on[d] ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 3));
          cyc[d]  = on[d];
          stb[d]  = on[d] && ($urandom_range(0, 7) != 0);
        end
        left[d]--;
        we[d]  = 1'($urandom_range(0, 1));
        adr[d] = 8'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
        dat[d] = 8'($urandom);
      end
    end

    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    repeat (10) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
